// File: rtl/clk_rst_seq.sv
// Board clock/reset block: debounced switch reset, staged per-channel reset
// release, and NCH runtime-programmable clock dividers with enable pulses.
module clk_rst_seq #(
  parameter int NCH       = 4,
  parameter int DIVW      = 8,
  parameter int DEB_CYC   = 16,
  parameter int STAGE_CYC = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sw_reset_n,
  input  logic                soft_rst,
  input  logic [NCH*DIVW-1:0] div_cfg,
  input  logic                cfg_load,
  output logic [NCH-1:0]      div_clk,
  output logic [NCH-1:0]      div_en,
  output logic [NCH-1:0]      chan_rst_n,
  output logic                seq_done
);
  localparam int DCW = $clog2(DEB_CYC + 1);
  localparam int SCW = (STAGE_CYC > 1) ? $clog2(STAGE_CYC) : 1;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {HOLD = 2'd0, RELEASE = 2'd1, RUN = 2'd2} state_e;

  state_e                   state_q, state_d;
  logic                     sync1_q, sw_s_q;
  logic [DCW-1:0]           deb_q, deb_d;
  logic [SCW-1:0]           stg_q, stg_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [NCH-1:0]           rst_n_q, rst_n_d;
  logic                     done_q, done_d;
  logic                     deb_ok_s, abort_s;
  logic [NCH-1:0][DIVW-1:0] cnt_q, cnt_d, dreg_q, dreg_d, cfg_s;
  logic [NCH-1:0]           dclk_q, dclk_d, den_q, den_d, pend_q, pend_d;

  assign cfg_s    = div_cfg;
  assign deb_ok_s = (deb_q == DCW'(DEB_CYC));
  // Reset assertion is immediate; only release goes through debounce.
  assign abort_s  = !sw_s_q || soft_rst;

  // Debounce counter: saturates at DEB_CYC, clears on any low sample.
  always_comb begin
    deb_d = deb_q;
    if (!sw_s_q) begin
      deb_d = '0;
    end else if (deb_ok_s) begin
      deb_d = deb_q;
    end else begin
      deb_d = deb_q + DCW'(1);
    end
  end

  // Sequencer next state: abort wins over a coincident release tick.
  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = 1'b0;
    if (abort_s) begin
      state_d = HOLD;
      stg_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
    end else begin
      case (state_q)
        HOLD: begin
          rst_n_d = '0;
          stg_d   = '0;
          idx_d   = '0;
          if (deb_ok_s) begin
            state_d = RELEASE;
          end else begin
            state_d = HOLD;
          end
        end
        RELEASE: begin
          if (stg_q == SCW'(STAGE_CYC - 1)) begin
            rst_n_d[idx_q] = 1'b1;
            stg_d          = '0;
            idx_d          = idx_q + IW'(1);
            if (idx_q == IW'(NCH - 1)) begin
              state_d = RUN;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            stg_d = stg_q + SCW'(1);
          end
        end
        RUN: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = HOLD;
          rst_n_d = '0;
        end
      endcase
    end
  end

  // Dividers held clear unless released both now and next cycle, so an
  // abort clears div_clk on the same edge that drops chan_rst_n.
  always_comb begin
    cnt_d  = cnt_q;
    dreg_d = dreg_q;
    dclk_d = dclk_q;
    den_d  = den_q;
    pend_d = pend_q;
    for (int i = 0; i < NCH; i++) begin
      if (!(rst_n_q[i] && rst_n_d[i])) begin
        cnt_d[i]  = '0;
        dclk_d[i] = 1'b0;
        den_d[i]  = 1'b0;
        dreg_d[i] = cfg_s[i];
        pend_d[i] = 1'b0;
      end else if (cnt_q[i] == dreg_q[i]) begin
        cnt_d[i]  = '0;
        dclk_d[i] = !dclk_q[i];
        den_d[i]  = !dclk_q[i];
        dreg_d[i] = pend_q[i] ? cfg_s[i] : dreg_q[i];
        pend_d[i] = cfg_load;
      end else begin
        cnt_d[i]  = cnt_q[i] + DIVW'(1);
        den_d[i]  = 1'b0;
        pend_d[i] = pend_q[i] | cfg_load;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      sync1_q <= 1'b0;
      sw_s_q  <= 1'b0;
      deb_q   <= '0;
      stg_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      dreg_q  <= cfg_s;
      dclk_q  <= '0;
      den_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      sync1_q <= sw_reset_n;
      sw_s_q  <= sync1_q;
      deb_q   <= deb_d;
      stg_q   <= stg_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      dreg_q  <= dreg_d;
      dclk_q  <= dclk_d;
      den_q   <= den_d;
      pend_q  <= pend_d;
    end
  end

  assign div_clk    = dclk_q;
  assign div_en     = den_q;
  assign chan_rst_n = rst_n_q;
  assign seq_done   = done_q;
endmodule
